mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_pkg.sv | 17 +
 rtl/mul_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared op encodings and FSM states for the iterative multiply/divide unit.
package mul_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, HI/LO results.
// Optional MUL_DIV_MTHILO_EN adds direct HI/LO writes while idle.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
`ifdef MUL_DIV_MTHILO_EN
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WrData,
`endif
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] v,
    input logic             s
  );
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  state_e          state, state_nx;
  logic [CW-1:0]   cnt;
  op_e             op_q;
  logic            sa, sb, dz;
  logic [WIDTH-1:0] r, q, d;

  logic            accept, last, sgn, bzero;
  logic            run_st, fix_st, fix_wr;

  logic [WIDTH:0]     msum, dshift, ddiff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo, rem;

  assign sgn    = ~Op[0];
  assign bzero  = (B == '0);
  assign accept = (state == IDLE) && Start;
  assign last   = (cnt == CW'(WIDTH));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (Start) begin
          // Divide by zero has nothing to iterate on.
          if (Op[1] && bzero) state_nx = FIX;
          else                state_nx = RUN;
        end
      end
      RUN: begin
        if (last) state_nx = FIX;
      end
      FIX: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy   = (state != IDLE);
    run_st = (state == RUN);
    fix_st = (state == FIX);
    fix_wr = fix_st && !dz;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (run_st && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    msum   = {1'b0, r} + (q[0] ? {1'b0, d} : '0);
    dshift = {r, q[WIDTH-1]};
    ddiff  = dshift - {1'b0, d};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q <= OP_MULT;
      sa   <= 1'b0;
      sb   <= 1'b0;
      dz   <= 1'b0;
      r    <= '0;
      q    <= '0;
      d    <= '0;
    end else if (accept) begin
      op_q <= op_e'(Op);
      sa   <= sgn && A[WIDTH-1];
      sb   <= sgn && B[WIDTH-1];
      dz   <= Op[1] && bzero;
      r    <= '0;
      q    <= mag(A, sgn);
      d    <= mag(B, sgn);
    end else if (run_st && !last) begin
      if (!op_q[1]) begin
        r <= msum[WIDTH:1];
        q <= {msum[0], q[WIDTH-1:1]};
      end else if (!ddiff[WIDTH]) begin
        r <= ddiff[WIDTH-1:0];
        q <= {q[WIDTH-2:0], 1'b1};
      end else begin
        r <= dshift[WIDTH-1:0];
        q <= {q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Magnitudes were iterated; restore signs here.
  always_comb begin
    prod   = {r, q};
    prod_s = (sa ^ sb) ? -prod : prod;
    quo    = (sa ^ sb) ? -q : q;
    rem    = sa ? -r : r;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      Done    <= fix_st;
      DivZero <= fix_st && dz;
      if (fix_wr) begin
        if (op_q[1]) begin
          Hi <= rem;
          Lo <= quo;
        end else begin
          Hi <= prod_s[2*WIDTH-1:WIDTH];
          Lo <= prod_s[WIDTH-1:0];
        end
      end
`ifdef MUL_DIV_MTHILO_EN
      else if (state == IDLE) begin
        if (HiWrite) Hi <= WrData;
        if (LoWrite) Lo <= WrData;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32).
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy, Done, DivZero;
  logic [W-1:0] Hi, Lo;
`ifdef MUL_DIV_MTHILO_EN
  logic         HiWrite = 1'b0;
  logic         LoWrite = 1'b0;
  logic [W-1:0] WrData = '0;
`endif

  int checks = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .Clock(Clock),
    .Reset(Reset),
`ifdef MUL_DIV_MTHILO_EN
    .HiWrite(HiWrite),
    .LoWrite(LoWrite),
    .WrData(WrData),
`endif
    .Start(Start),
    .Op(Op),
    .A(A),
    .B(B),
    .Busy(Busy),
    .Done(Done),
    .DivZero(DivZero),
    .Hi(Hi),
    .Lo(Lo)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t v[13];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       output int lat,
                       output logic bz);
    @(negedge Clock);
    Start = 1'b1;
    Op = op;
    A = a;
    B = b;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    bz = Busy;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge Clock);
      #1;
      if (Done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic bz;
    logic [W-1:0] eh, el;
    int seen;

    v[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h7,
              32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    v[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001, 1'b0};
    v[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    v[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF,
              32'h0, 32'h80000000, 1'b0};
    v[4]  = '{OP_DIVU,  32'd100, 32'h0,
              32'h0, 32'h0, 1'b1};
    v[5]  = '{OP_DIVU,  32'd100, 32'd7,
              32'd2, 32'd14, 1'b0};
    v[6]  = '{OP_DIV,   32'd7, 32'hFFFFFFFE,
              32'd1, 32'hFFFFFFFD, 1'b0};
    v[7]  = '{OP_MULTU, 32'h00010000, 32'h00010000,
              32'h1, 32'h0, 1'b0};
    v[8]  = '{OP_MULT,  32'h80000000, 32'h80000000,
              32'h40000000, 32'h0, 1'b0};
    v[9]  = '{OP_DIV,   32'd5, 32'h0,
              32'h0, 32'h0, 1'b1};
    v[10] = '{OP_MULT,  32'd3, 32'hFFFFFFFB,
              32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    v[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,
              32'd5, 32'h19999999, 1'b0};
    v[12] = '{OP_DIV,   32'd0, 32'd5,
              32'h0, 32'h0, 1'b0};

    #1;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_dz", 64'(DivZero), 64'd0);
    chk("rst_hi", 64'(Hi), 64'd0);
    chk("rst_lo", 64'(Lo), 64'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    eh = '0;
    el = '0;
    for (int i = 0; i < 13; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, lat, bz);
      if (!v[i].dz) begin
        eh = v[i].hi;
        el = v[i].lo;
      end
      chk($sformatf("v%0d_busy", i), 64'(bz), 64'd1);
      chk($sformatf("v%0d_lat", i), 64'(lat),
          64'(v[i].dz ? 1 : W + 2));
      chk($sformatf("v%0d_dz", i), 64'(DivZero),
          64'(v[i].dz));
      chk($sformatf("v%0d_hi", i), 64'(Hi), 64'(eh));
      chk($sformatf("v%0d_lo", i), 64'(Lo), 64'(el));
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d_pulse", i), 64'(Done), 64'd0);
      chk($sformatf("v%0d_idle", i), 64'(Busy), 64'd0);
    end

    // Start re-pulsed while busy must be ignored.
    @(negedge Clock);
    Start = 1'b1;
    Op = OP_MULT;
    A = 32'd6;
    B = 32'd7;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge Clock);
      #1;
      if (k == 4) begin
        Start = 1'b1;
        Op = OP_MULTU;
        A = 32'd2;
        B = 32'd3;
      end
      if (k == 5) begin
        Start = 1'b0;
        chk("ign_busy", 64'(Busy), 64'd1);
      end
      if (Done) begin
        lat = k;
        break;
      end
    end
    chk("ign_lat", 64'(lat), 64'(W + 2));
    chk("ign_hi", 64'(Hi), 64'd0);
    chk("ign_lo", 64'(Lo), 64'd42);
    repeat (3) @(posedge Clock);
    #1;
    chk("ign_idle", 64'(Busy), 64'd0);

    // Reset mid-run aborts without Done.
    @(negedge Clock);
    Start = 1'b1;
    Op = OP_MULT;
    A = 32'd9;
    B = 32'd9;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clock);
      #1;
      if (Done) seen++;
    end
    chk("run_hi_hold", 64'(Hi), 64'd0);
    chk("run_lo_hold", 64'(Lo), 64'd42);
    Reset = 1'b1;
    #1;
    chk("arst_busy", 64'(Busy), 64'd0);
    chk("arst_hi", 64'(Hi), 64'd0);
    chk("arst_lo", 64'(Lo), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int k = 0; k < W + 5; k++) begin
      @(posedge Clock);
      #1;
      if (Done) seen++;
    end
    chk("arst_nodone", 64'(seen), 64'd0);

    do_op(OP_MULTU, 32'd3, 32'd4, lat, bz);
    chk("post_lat", 64'(lat), 64'(W + 2));
    chk("post_hi", 64'(Hi), 64'd0);
    chk("post_lo", 64'(Lo), 64'd12);

`ifdef MUL_DIV_MTHILO_EN
    @(negedge Clock);
    HiWrite = 1'b1;
    WrData = 32'h12345678;
    @(posedge Clock);
    #1;
    HiWrite = 1'b0;
    chk("mthi", 64'(Hi), 64'h12345678);
    chk("mthi_lo", 64'(Lo), 64'd12);
    @(negedge Clock);
    Start = 1'b1;
    Op = OP_MULTU;
    A = 32'd5;
    B = 32'd5;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    HiWrite = 1'b1;
    LoWrite = 1'b1;
    WrData = 32'hDEADBEEF;
    @(posedge Clock);
    #1;
    HiWrite = 1'b0;
    LoWrite = 1'b0;
    chk("mthi_busy", 64'(Hi), 64'h12345678);
    chk("mtlo_busy", 64'(Lo), 64'd12);
    lat = -1;
    for (int k = 2; k <= 100; k++) begin
      @(posedge Clock);
      #1;
      if (Done) begin
        lat = k;
        break;
      end
    end
    chk("mt_op_lat", 64'(lat), 64'(W + 2));
    chk("mt_op_lo", 64'(Lo), 64'd25);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
